// File: rtl/gray_sync_decoder_if.sv
// Bus bundle for gray_sync_decoder: gray input, error clear and decoded outputs.
interface gray_sync_decoder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic [WIDTH-1:0] binary_out;
    logic             bin_valid;
    logic [WIDTH-1:0] step_out;
    logic             wrap_pulse;
    logic             step_err;

    modport master (
        output gray_in, err_clr,
        input  binary_out, bin_valid, step_out, wrap_pulse, step_err
    );

    modport slave (
        input  gray_in, err_clr,
        output binary_out, bin_valid, step_out, wrap_pulse, step_err
    );
endinterface

// File: rtl/gray_sync_decoder.sv
// Two-flop synchronised gray-to-binary decoder with step, wrap and illegal-transition flag.
// Define GRAY_STEP_CHECK_EN to build the sticky multi-bit-change detector on step_err.
module gray_sync_decoder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_sync_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_PRIME,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] dec_c;
    logic [WIDTH-1:0] prev_gray_c;
    logic [WIDTH-1:0] gray_diff_c;
    logic             multi_bit_c;

    // Gray-to-binary decode of the synchronised word
    always_comb begin
        dec_c            = '0;
        dec_c[WIDTH-1]   = sync2_q[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            dec_c[i] = dec_c[i+1] ^ sync2_q[i];
        end
    end

    // binary_q is the previous decoded sample, so re-encoding it recovers the previous sync2
    assign prev_gray_c = binary_q ^ (binary_q >> 1);
    assign gray_diff_c = sync2_q ^ prev_gray_c;
    assign multi_bit_c = (gray_diff_c & (gray_diff_c - WIDTH'(1))) != '0;

    always_comb begin
        state_d  = state_q;
        binary_d = binary_q;
        step_d   = step_q;
        wrap_d   = 1'b0;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            ST_INIT:  state_d = ST_FILL;
            ST_FILL:  state_d = ST_PRIME;
            ST_PRIME: begin
                binary_d = dec_c;
                step_d   = '0;
                valid_d  = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                binary_d = dec_c;
                step_d   = dec_c - binary_q;
                wrap_d   = (binary_q == '1) && (dec_c == '0);
            end
            default:  state_d = ST_INIT;
        endcase
`ifdef GRAY_STEP_CHECK_EN
        // A fresh error wins over a simultaneous clear
        if (bus.err_clr) err_d = 1'b0;
        if (state_q == ST_RUN && multi_bit_c) err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            sync1_q  <= '0;
            sync2_q  <= '0;
            binary_q <= '0;
            step_q   <= '0;
            wrap_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus.gray_in;
            sync2_q  <= sync1_q;
            binary_q <= binary_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus.binary_out = binary_q;
    assign bus.step_out   = step_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.bin_valid  = valid_q;
`ifdef GRAY_STEP_CHECK_EN
    assign bus.step_err   = err_q;
`else
    assign bus.step_err   = 1'b0;

    logic unused_chk;
    assign unused_chk = bus.err_clr ^ err_q ^ multi_bit_c;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=4) with hand-computed expectations.
module tb_gray_sync_decoder;

    localparam int unsigned WIDTH = 4;
`ifdef GRAY_STEP_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    gray_sync_decoder_if #(.WIDTH(WIDTH)) bus ();

    gray_sync_decoder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a gray word and let it propagate (one value per 4 cycles)
    task automatic settle(input logic [3:0] g);
        bus.gray_in = g;
        repeat (4) tick();
    endtask

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b0;
        bus.gray_in = 4'b0000;
        bus.err_clr = 1'b0;
        #3;
        check_eq("rst_bin",   16'(bus.binary_out), 16'd0);
        check_eq("rst_valid", 16'(bus.bin_valid),  16'd0);
        check_eq("rst_step",  16'(bus.step_out),   16'd0);
        check_eq("rst_wrap",  16'(bus.wrap_pulse), 16'd0);
        check_eq("rst_err",   16'(bus.step_err),   16'd0);

        // Reset release with gray held at zero
        tick();
        rst = 1'b1;
        tick(); check_eq("fill_valid1", 16'(bus.bin_valid), 16'd0);
        tick(); check_eq("fill_valid2", 16'(bus.bin_valid), 16'd0);
        tick();
        check_eq("prime_valid", 16'(bus.bin_valid),  16'd1);
        check_eq("prime_bin",   16'(bus.binary_out), 16'd0);
        check_eq("prime_step",  16'(bus.step_out),   16'd0);

        // Full up-count 1..15 with 3-edge latency
        for (int v = 1; v < 16; v++) begin
            bus.gray_in = to_gray(v);
            tick(); tick();
            check_eq("cnt_lat",  16'(bus.binary_out), 16'(v - 1));
            tick();
            check_eq("cnt_bin",  16'(bus.binary_out), 16'(v));
            check_eq("cnt_step", 16'(bus.step_out),   16'd1);
            check_eq("cnt_wrap", 16'(bus.wrap_pulse), 16'd0);
            check_eq("cnt_err",  16'(bus.step_err),   16'd0);
            tick();
            check_eq("cnt_hold", 16'(bus.step_out),   16'd0);
        end

        // Wrap 15 -> 0
        bus.gray_in = 4'b0000;
        repeat (3) tick();
        check_eq("wrap_bin",   16'(bus.binary_out), 16'd0);
        check_eq("wrap_pulse", 16'(bus.wrap_pulse), 16'd1);
        check_eq("wrap_step",  16'(bus.step_out),   16'd1);
        tick();
        check_eq("wrap_once",  16'(bus.wrap_pulse), 16'd0);

        // Countdown 2 -> 1
        settle(4'b0001);
        settle(4'b0011);
        check_eq("dn_pre", 16'(bus.binary_out), 16'd2);
        bus.gray_in = 4'b0001;
        repeat (3) tick();
        check_eq("dn_bin",  16'(bus.binary_out), 16'd1);
        check_eq("dn_step", 16'(bus.step_out),   16'hF);
        check_eq("dn_wrap", 16'(bus.wrap_pulse), 16'd0);
        check_eq("dn_err",  16'(bus.step_err),   16'd0);
        tick();

        // Illegal three-bit jump 0001 -> 0110
        bus.gray_in = 4'b0110;
        repeat (3) tick();
        check_eq("jmp_bin",   16'(bus.binary_out), 16'd4);
        check_eq("jmp_err",   16'(bus.step_err),   16'(CHK));
        tick();
        check_eq("jmp_stick", 16'(bus.step_err),   16'(CHK));
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("clr_err",   16'(bus.step_err),   16'd0);

        // Illegal jump back coinciding with err_clr: the error wins
        bus.gray_in = 4'b0001;
        tick(); tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("prio_bin", 16'(bus.binary_out), 16'd1);
        check_eq("prio_err", 16'(bus.step_err),   16'(CHK));
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("clr2_err", 16'(bus.step_err),   16'd0);
        tick();

        // Walk up to 9, then reset between edges
        for (int v = 2; v <= 9; v++) settle(to_gray(v));
        check_eq("mid_bin", 16'(bus.binary_out), 16'd9);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_bin",   16'(bus.binary_out), 16'd0);
        check_eq("arst_valid", 16'(bus.bin_valid),  16'd0);
        check_eq("arst_step",  16'(bus.step_out),   16'd0);
        check_eq("arst_wrap",  16'(bus.wrap_pulse), 16'd0);
        check_eq("arst_err",   16'(bus.step_err),   16'd0);
        tick();
        check_eq("arst_hold", 16'(bus.bin_valid), 16'd0);
        rst = 1'b1;
        tick(); check_eq("re_valid1", 16'(bus.bin_valid), 16'd0);
        tick(); check_eq("re_valid2", 16'(bus.bin_valid), 16'd0);
        tick();
        check_eq("re_valid3", 16'(bus.bin_valid),  16'd1);
        check_eq("re_bin",    16'(bus.binary_out), 16'd9);
        check_eq("re_step",   16'(bus.step_out),   16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
